// File: rtl/game_round_ctrl.sv
// Round sequencer: RNG seeding, puzzle draw with wildcard rejection, countdown and score.
// Build option SKIP_PENALTY_EN: a skip in PLAY costs one point (saturating at 0).
module game_round_ctrl #(
   parameter int ROUND_SECS = 30,
   parameter int MAX_WILD   = 1,
   parameter int MAX_TRIES  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       skip,
   input  logic       tick_1hz,
   input  logic       answer_valid,
   input  logic       answer_ok,
   input  logic [3:0] rng_d0,
   input  logic [3:0] rng_d1,
   input  logic [3:0] rng_d2,
   input  logic [3:0] rng_d3,
   output logic       seed_en,
   output logic [3:0] p0,
   output logic [3:0] p1,
   output logic [3:0] p2,
   output logic [3:0] p3,
   output logic       round_active,
   output logic       timeout,
   output logic       wrong_pulse,
   output logic [7:0] time_left,
   output logic [7:0] score,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEED = 3'd1,
      S_DRAW = 3'd2,
      S_PLAY = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [7:0] SECS     = 8'(ROUND_SECS);
   localparam logic [2:0] WILD_LIM = 3'(MAX_WILD);
   localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

   state_t     cur, nxt;
   logic       seeded, seeded_n;
   logic [1:0] seed_cnt, seed_cnt_n;
   logic [3:0] tries, tries_n;
   logic [3:0] p0_n, p1_n, p2_n, p3_n;
   logic [7:0] time_left_n, score_n;
   logic       seed_en_n, wrong_n;
   logic       go_draw;
   logic [2:0] wild;

   function automatic logic [2:0] is_wild(input logic [3:0] d);
      return {2'b00, d >= 4'd10};
   endfunction

   assign wild = is_wild(rng_d0) + is_wild(rng_d1)
               + is_wild(rng_d2) + is_wild(rng_d3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur          <= S_IDLE;
         seeded       <= 1'b0;
         seed_cnt     <= 2'd0;
         tries        <= 4'd0;
         p0           <= 4'd0;
         p1           <= 4'd0;
         p2           <= 4'd0;
         p3           <= 4'd0;
         time_left    <= 8'd0;
         score        <= 8'd0;
         seed_en      <= 1'b0;
         wrong_pulse  <= 1'b0;
         round_active <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         cur          <= nxt;
         seeded       <= seeded_n;
         seed_cnt     <= seed_cnt_n;
         tries        <= tries_n;
         p0           <= p0_n;
         p1           <= p1_n;
         p2           <= p2_n;
         p3           <= p3_n;
         time_left    <= time_left_n;
         score        <= score_n;
         seed_en      <= seed_en_n;
         wrong_pulse  <= wrong_n;
         round_active <= (nxt == S_PLAY);
         timeout      <= (nxt == S_DONE);
      end
   end

   assign state = cur;

   always_comb begin
      nxt         = cur;
      seeded_n    = seeded;
      seed_cnt_n  = seed_cnt;
      tries_n     = tries;
      p0_n        = p0;
      p1_n        = p1;
      p2_n        = p2;
      p3_n        = p3;
      time_left_n = time_left;
      score_n     = score;
      seed_en_n   = 1'b0;
      wrong_n     = 1'b0;
      go_draw     = 1'b0;
      unique case (cur)
         S_IDLE: begin
            if (start) begin
               if (!seeded) begin
                  nxt        = S_SEED;
                  seed_en_n  = 1'b1;
                  seeded_n   = 1'b1;
                  seed_cnt_n = 2'd0;
               end else begin
                  nxt = S_DRAW;
               end
            end
         end
         // three cycles let the seeded RNG state reach its outputs
         S_SEED: begin
            if (seed_cnt == 2'd2) begin
               nxt = S_DRAW;
            end else begin
               seed_cnt_n = seed_cnt + 2'd1;
            end
         end
         S_DRAW: begin
            if (wild <= WILD_LIM || tries == LAST_TRY) begin
               p0_n        = rng_d0;
               p1_n        = rng_d1;
               p2_n        = rng_d2;
               p3_n        = rng_d3;
               time_left_n = SECS;
               tries_n     = 4'd0;
               nxt         = S_PLAY;
            end else begin
               tries_n = tries + 4'd1;
            end
         end
         S_PLAY: begin
            if (answer_valid && answer_ok) begin
               if (score != 8'hFF) score_n = score + 8'd1;
               nxt = S_DRAW;
            end else begin
               if (answer_valid) begin
                  wrong_n = 1'b1;
               end else if (skip) begin
                  go_draw = 1'b1;
                  nxt     = S_DRAW;
`ifdef SKIP_PENALTY_EN
                  if (score != 8'h00) score_n = score - 8'd1;
`endif
               end
               // a tick alongside a wrong answer or skip still counts
               if (tick_1hz && time_left != 8'd0) begin
                  time_left_n = time_left - 8'd1;
                  if (time_left == 8'd1 && !go_draw) nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               score_n = 8'd0;
               nxt     = S_DRAW;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed test-plan steps plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_game_round_ctrl;

   localparam int ROUND = 30;
   localparam int MWILD = 1;
   localparam int MTRY  = 8;
`ifdef SKIP_PENALTY_EN
   localparam int SKIP_EXP = 4;
`else
   localparam int SKIP_EXP = 5;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 0, skip = 0, tick_1hz = 0;
   logic answer_valid = 0, answer_ok = 0;
   logic [3:0] rd0 = 0, rd1 = 0, rd2 = 0, rd3 = 0;
   logic seed_en, round_active, timeout, wrong_pulse;
   logic [3:0] p0, p1, p2, p3;
   logic [7:0] time_left, score;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;

   game_round_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .skip(skip),
      .tick_1hz(tick_1hz), .answer_valid(answer_valid),
      .answer_ok(answer_ok), .rng_d0(rd0), .rng_d1(rd1),
      .rng_d2(rd2), .rng_d3(rd3), .seed_en(seed_en),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3),
      .round_active(round_active), .timeout(timeout),
      .wrong_pulse(wrong_pulse), .time_left(time_left),
      .score(score), .state(state)
   );

   always #5 clk = ~clk;

   // behavioural model: mode numbers are the published state codes
   int m_st = 0, m_seeded = 0, m_seed_left = 0, m_tries = 0;
   int m_p[4] = '{0, 0, 0, 0};
   int m_time = 0, m_score = 0, m_seed_en = 0, m_wrong = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0; m_seeded = 0; m_seed_left = 0; m_tries = 0;
         m_p = '{0, 0, 0, 0};
         m_time = 0; m_score = 0; m_seed_en = 0; m_wrong = 0;
      end else begin
         int w;
         int d[4];
         d = '{int'(rd0), int'(rd1), int'(rd2), int'(rd3)};
         m_seed_en = 0;
         m_wrong = 0;
         case (m_st)
            0: if (start) begin
               if (m_seeded == 0) begin
                  m_st = 1; m_seed_left = 3;
                  m_seed_en = 1; m_seeded = 1;
               end else m_st = 2;
            end
            1: begin
               m_seed_left--;
               if (m_seed_left == 0) m_st = 2;
            end
            2: begin
               w = 0;
               foreach (d[i]) if (d[i] >= 10) w++;
               if (w <= MWILD || m_tries == MTRY - 1) begin
                  m_p = d; m_time = ROUND; m_tries = 0; m_st = 3;
               end else m_tries++;
            end
            3: begin
               if (answer_valid && answer_ok) begin
                  if (m_score < 255) m_score++;
                  m_st = 2;
               end else begin
                  if (answer_valid) m_wrong = 1;
                  else if (skip) begin
                     m_st = 2;
`ifdef SKIP_PENALTY_EN
                     if (m_score > 0) m_score--;
`endif
                  end
                  if (tick_1hz && m_time > 0) begin
                     m_time--;
                     if (m_time == 0 && m_st == 3) m_st = 4;
                  end
               end
            end
            4: if (start) begin
               m_score = 0; m_st = 2;
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m.state", 32'(state), 32'(m_st));
         chk("m.seed_en", 32'(seed_en), 32'(m_seed_en));
         chk("m.p0", 32'(p0), 32'(m_p[0]));
         chk("m.p1", 32'(p1), 32'(m_p[1]));
         chk("m.p2", 32'(p2), 32'(m_p[2]));
         chk("m.p3", 32'(p3), 32'(m_p[3]));
         chk("m.round_active", 32'(round_active), 32'(m_st == 3));
         chk("m.timeout", 32'(timeout), 32'(m_st == 4));
         chk("m.wrong_pulse", 32'(wrong_pulse), 32'(m_wrong));
         chk("m.time_left", 32'(time_left), 32'(m_time));
         chk("m.score", 32'(score), 32'(m_score));
      end
   end

   task automatic clr();
      start = 0; skip = 0; tick_1hz = 0;
      answer_valid = 0; answer_ok = 0;
   endtask

   task automatic set_rng(input int a, input int b,
                          input int c, input int d);
      rd0 = 4'(a); rd1 = 4'(b); rd2 = 4'(c); rd3 = 4'(d);
   endtask

   task automatic nc();
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".state"}, 32'(state), 0);
      chk({tag, ".score"}, 32'(score), 0);
      chk({tag, ".time_left"}, 32'(time_left), 0);
      chk({tag, ".p0"}, 32'(p0), 0);
      chk({tag, ".p1"}, 32'(p1), 0);
      chk({tag, ".flags"},
          32'({seed_en, round_active, timeout, wrong_pulse}), 0);
   endtask

   task automatic correct();
      answer_valid = 1; answer_ok = 1;
      nc(); clr();
      nc();
   endtask

   initial begin
      clr();
      set_rng(0, 0, 0, 0);
      repeat (2) nc();
      cmp_en = 1;
      chk_reset("rst0");
      #1 rst = 0;
      repeat (9) nc();
      start = 1;
      nc(); clr();
      chk("seed.pulse", 32'(seed_en), 1);
      chk("seed.state1", 32'(state), 1);
      set_rng(10, 10, 3, 4);
      nc();
      chk("seed.once", 32'(seed_en), 0);
      chk("seed.state2", 32'(state), 1);
      nc();
      chk("seed.state3", 32'(state), 1);
      for (int i = 0; i < 4; i++) begin
         nc();
         chk("draw.wait", 32'(state), 2);
         if (i == 3) set_rng(10, 2, 3, 4);
      end
      nc();
      chk("draw.play", 32'(state), 3);
      chk("draw.p0", 32'(p0), 10);
      chk("draw.p1", 32'(p1), 2);
      chk("draw.p3", 32'(p3), 4);
      chk("draw.time", 32'(time_left), 30);

      set_rng(1, 2, 3, 4);
      skip = 1;
      nc(); clr();
      chk("skip0.state", 32'(state), 2);
      chk("skip0.score", 32'(score), 0);
      nc();
      for (int i = 0; i < 5; i++) correct();
      chk("five.score", 32'(score), 5);
      skip = 1;
      nc(); clr();
      chk("skip5.score", 32'(score), SKIP_EXP);
      nc();

      answer_valid = 1; answer_ok = 0;
      nc(); clr();
      chk("wrong.pulse", 32'(wrong_pulse), 1);
      chk("wrong.state", 32'(state), 3);
      nc();
      chk("wrong.once", 32'(wrong_pulse), 0);

      for (int i = 0; i < 30; i++) begin
         tick_1hz = 1;
         nc(); clr();
         chk("tick.time", 32'(time_left), 29 - i);
      end
      chk("done.state", 32'(state), 4);
      chk("done.timeout", 32'(timeout), 1);
      chk("done.active", 32'(round_active), 0);
      repeat (3) nc();
      chk("done.hold_p1", 32'(p1), 2);
      start = 1;
      nc(); clr();
      chk("restart.state", 32'(state), 2);
      chk("restart.score", 32'(score), 0);
      chk("restart.noseed", 32'(seed_en), 0);
      nc();

      for (int i = 0; i < 29; i++) begin
         tick_1hz = 1;
         nc(); clr();
      end
      chk("race.time1", 32'(time_left), 1);
      tick_1hz = 1; answer_valid = 1; answer_ok = 1;
      nc(); clr();
      chk("race.state", 32'(state), 2);
      chk("race.score", 32'(score), 1);
      nc();
      chk("race.reload", 32'(time_left), 30);

      set_rng(10, 10, 10, 10);
      answer_valid = 1; answer_ok = 1;
      nc(); clr();
      for (int i = 0; i < 8; i++) begin
         chk("wild8.draw", 32'(state), 2);
         nc();
      end
      chk("wild8.play", 32'(state), 3);
      chk("wild8.p2", 32'(p2), 10);

      set_rng(1, 2, 3, 4);
      for (int i = 0; i < 300; i++) correct();
      chk("sat.score", 32'(score), 255);

      #1 rst = 1;
      nc();
      chk_reset("midrst");
      #1 rst = 0;
      nc();
      start = 1;
      nc(); clr();
      chk("reseed.pulse", 32'(seed_en), 1);
      repeat (6) nc();

      for (int c = 0; c < 5000; c++) begin
         start = ($urandom_range(0, 99) < 4);
         skip = ($urandom_range(0, 99) < 4);
         tick_1hz = ($urandom_range(0, 99) < 25);
         answer_valid = ($urandom_range(0, 99) < 6);
         answer_ok = $urandom_range(0, 1) != 0;
         rd0 = 4'($urandom_range(0, 15));
         rd1 = 4'($urandom_range(0, 15));
         rd2 = 4'($urandom_range(0, 15));
         rd3 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 499) == 0) begin
            #1 rst = 1;
            nc();
            #1 rst = 0;
         end else nc();
      end
      clr();
      nc();
      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the digit-puzzle game.
- Issues the one-time seed pulse to the digit RNG and samples its four free-running digit outputs into a stable puzzle, rejecting draws with too many wildcards.
- Runs a per-round countdown on a 1 Hz tick and keeps the score.
- Sits between the button debouncers / answer checker and the RNG and display logic.

Parameters:
- ROUND_SECS, 30, countdown loaded at each new puzzle (1..255).
- MAX_WILD, 1, maximum wildcard digits accepted in a puzzle (0..4).
- MAX_TRIES, 8, draw attempts before a puzzle is accepted regardless (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle debounced start/restart pulse
- skip  in  1  single-cycle skip-puzzle pulse
- tick_1hz  in  1  single-cycle 1 Hz enable
- answer_valid  in  1  answer checker result strobe
- answer_ok  in  1  answer correct; qualified by answer_valid
- rng_d0..rng_d3  in  4 each  RNG digit outputs; 0-9 are digits, 10 is wildcard
- seed_en  out  1  one-cycle seed pulse to the RNG
- p0..p3  out  4 each  latched puzzle digits
- round_active  out  1  high in PLAY
- timeout  out  1  high in DONE
- wrong_pulse  out  1  one-cycle pulse on a wrong answer
- time_left  out  8  seconds remaining
- score  out  8  saturating score
- state  out  3  IDLE=0, SEED=1, DRAW=2, PLAY=3, DONE=4

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; seeded flag 0; p0..p3 = 0; time_left 0; score 0; tries 0; seed_en, round_active, timeout and wrong_pulse all 0.
- Reset mid-round aborts immediately to these values. The RNG is reset with the same rst, so the next start re-seeds it.
- IDLE:
  - start with seeded=0: go to SEED; seed_en=1 for exactly the first SEED cycle; set seeded=1.
  - start with seeded=1 (not normally reachable): go to DRAW.
- SEED: lasts exactly 3 cycles so the seeded RNG state reaches rng_d*. If start arrives in cycle N, seed_en is high in N+1 and DRAW begins in N+4.
- DRAW: samples rng_d0..3 once per cycle.
  - A value >= 10 counts as a wildcard; the count is 0..4.
  - Accept when count <= MAX_WILD or tries == MAX_TRIES-1. On accept: latch p0..p3 (p0=rng_d0, and so on), set time_left=ROUND_SECS, clear tries, go to PLAY.
  - Otherwise increment tries and stay in DRAW. This gives at most MAX_TRIES cycles in DRAW.
  - start, skip, answer_valid and tick_1hz are ignored in DRAW.
- PLAY: priority order, highest first:
  1. answer_valid & answer_ok: score+1, saturating at 255; go to DRAW.
  2. answer_valid & !answer_ok: wrong_pulse=1 next cycle; stay in PLAY.
  3. skip: go to DRAW; score handling per the optional feature.
  4. tick_1hz: time_left-1. When time_left==1, the tick sets time_left=0 and goes to DONE.
- Simultaneous events in PLAY:
  - A correct answer beats an expiring tick in the same cycle: score counts and time_left is reloaded on the next accept.
  - A tick that coincides with a wrong answer or a skip is not lost; time_left still decrements, and a skip still goes to DRAW.
- DONE: timeout=1; p0..p3 hold. start clears score and goes to DRAW with no re-seed.
- time_left never underflows. p0..p3 change only on a DRAW accept.

Optional Feature:
- Macro SKIP_PENALTY_EN.
- Defined: skip in PLAY decrements score, saturating at 0.
- Undefined: skip leaves score unchanged.
- State transitions are identical in both builds.

Test Plan:
- Reset, then start pulse at cycle 10 -> seed_en high only in cycle 11; state=SEED in cycles 11-13; DRAW in cycle 14; one cycle later state=PLAY with time_left=30.
- In DRAW, drive rng_d={10,10,3,4} for 3 cycles then {10,2,3,4} -> puzzle latched as p0..p3=10,2,3,4 after 4 draw cycles, then PLAY. With rng_d held at {10,10,10,10}: accept after exactly 8 cycles.
- In PLAY, answer_valid=1, answer_ok=1 -> score 0 to 1, state DRAW then PLAY, time_left reloaded to 30. 300 correct answers -> score holds at 255.
- In PLAY, 30 tick_1hz pulses -> time_left reaches 0 and state=DONE with timeout=1. On the 30th tick, assert a correct answer together with the tick -> score increments and state goes to DRAW, not DONE.
- In PLAY, answer_valid=1, answer_ok=0 -> wrong_pulse high for exactly 1 cycle, state stays PLAY. skip at score=0 -> score stays 0 in both builds; at score=5 -> 4 with SKIP_PENALTY_EN, 5 without.
- Assert rst mid-PLAY -> all outputs return to reset values; the next start pulses seed_en again. In DONE, start -> score=0 and DRAW with no seed_en pulse.
